// File: rtl/ram_512_64_ctrl.sv
// ram_512_64_ctrl: clears a 512x64 1R1W RAM after reset, then shares its
// read and write ports between requesters A and B with round-robin grants.
module ram_512_64_ctrl #(
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [63:0] INIT_VALUE = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_rreq,
    input  logic [8:0]  a_raddr,
    output logic        a_rgnt,
    output logic        a_rvalid,
    output logic [63:0] a_rdata,
    input  logic        b_rreq,
    input  logic [8:0]  b_raddr,
    output logic        b_rgnt,
    output logic        b_rvalid,
    output logic [63:0] b_rdata,
    input  logic        a_wreq,
    input  logic [8:0]  a_waddr,
    input  logic [63:0] a_wdata,
    output logic        a_wgnt,
    input  logic        b_wreq,
    input  logic [8:0]  b_waddr,
    input  logic [63:0] b_wdata,
    output logic        b_wgnt,
    output logic        ram_re,
    output logic [8:0]  ram_raddr,
    input  logic [63:0] ram_rd,
    output logic        ram_we,
    output logic [8:0]  ram_waddr,
    output logic [63:0] ram_wr,
    output logic        init_done
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  clr_cnt_q, clr_cnt_d;
    // pointer value 0 means A has priority on the next contention
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        ra_q, rb_q;
    logic        run;
    logic        clearing;

    assign run      = rst & (state_q == S_RUN);
    assign clearing = rst & (state_q == S_INIT);

    assign a_rgnt = run & a_rreq & ~(b_rreq & rd_ptr_q);
    assign b_rgnt = run & b_rreq & ~(a_rreq & ~rd_ptr_q);
    assign a_wgnt = run & a_wreq & ~(b_wreq & wr_ptr_q);
    assign b_wgnt = run & b_wreq & ~(a_wreq & ~wr_ptr_q);

    assign ram_re    = a_rgnt | b_rgnt;
    assign ram_raddr = b_rgnt ? b_raddr : a_raddr;

    assign a_rvalid  = ra_q;
    assign b_rvalid  = rb_q;
    assign a_rdata   = ram_rd;
    assign b_rdata   = ram_rd;
    assign init_done = run;

    // write port: clear sequence owns it in INIT, arbitration in RUN
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = a_waddr;
        ram_wr    = a_wdata;
        if (clearing) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wr    = INIT_VALUE;
        end else begin
            ram_we = a_wgnt | b_wgnt;
            if (b_wgnt) begin
                ram_waddr = b_waddr;
                ram_wr    = b_wdata;
            end
        end
    end

    // next state: clear counter saturates at the last entry, RUN is absorbing
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_INIT) begin
            if (clr_cnt_q == 9'd511) begin
                state_d = S_RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + 9'd1;
            end
        end
    end

    // round-robin: after a grant the other requester gets priority
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (a_rgnt | b_rgnt) begin
            rd_ptr_d = a_rgnt;
        end
        if (a_wgnt | b_wgnt) begin
            wr_ptr_d = a_wgnt;
        end
    end

    // sequencer state and clear counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT_EN ? S_INIT : S_RUN;
            clr_cnt_q <= 9'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // arbitration pointers and tagged read-response valids
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ra_q     <= 1'b0;
            rb_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ra_q     <= a_rgnt;
            rb_q     <= b_rgnt;
        end
    end

endmodule

// File: tb/tb_ram_512_64_ctrl.sv
// tb_ram_512_64_ctrl: random and directed traffic against a behavioural
// model of the clear sequence, round-robin ports and RAM contents.
module tb_ram_512_64_ctrl;

    localparam logic [63:0] IV = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_rreq = 0, b_rreq = 0, a_wreq = 0, b_wreq = 0;
    logic [8:0]  a_raddr = 0, b_raddr = 0, a_waddr = 0, b_waddr = 0;
    logic [63:0] a_wdata = 0, b_wdata = 0;
    logic        a_rgnt, b_rgnt, a_wgnt, b_wgnt;
    logic        a_rvalid, b_rvalid;
    logic [63:0] a_rdata, b_rdata;
    logic        ram_re, ram_we, init_done;
    logic [8:0]  ram_raddr, ram_waddr;
    logic [63:0] ram_rd = 64'h0, ram_wr;
    logic [63:0] ram_mem [512];

    logic        z_rgnt_a, z_rgnt_b, z_wgnt_a, z_wgnt_b;
    logic        z_rv_a, z_rv_b, z_re, z_we, z_done;
    logic [63:0] z_rd_a, z_rd_b, z_wr;
    logic [8:0]  z_raddr, z_waddr;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_512_64_ctrl #(.INIT_EN(1'b1), .INIT_VALUE(IV)) dut (
        .clk(clk), .rst(rst),
        .a_rreq(a_rreq), .a_raddr(a_raddr), .a_rgnt(a_rgnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_rreq(b_rreq), .b_raddr(b_raddr), .b_rgnt(b_rgnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .a_wreq(a_wreq), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wgnt(a_wgnt),
        .b_wreq(b_wreq), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wgnt(b_wgnt),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rd(ram_rd),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wr(ram_wr),
        .init_done(init_done)
    );

    ram_512_64_ctrl #(.INIT_EN(1'b0), .INIT_VALUE(64'h0)) dut0 (
        .clk(clk), .rst(rst),
        .a_rreq(1'b0), .a_raddr(9'd0), .a_rgnt(z_rgnt_a),
        .a_rvalid(z_rv_a), .a_rdata(z_rd_a),
        .b_rreq(1'b0), .b_raddr(9'd0), .b_rgnt(z_rgnt_b),
        .b_rvalid(z_rv_b), .b_rdata(z_rd_b),
        .a_wreq(1'b0), .a_waddr(9'd0), .a_wdata(64'd0), .a_wgnt(z_wgnt_a),
        .b_wreq(1'b0), .b_waddr(9'd0), .b_wdata(64'd0), .b_wgnt(z_wgnt_b),
        .ram_re(z_re), .ram_raddr(z_raddr), .ram_rd(64'd0),
        .ram_we(z_we), .ram_waddr(z_waddr), .ram_wr(z_wr),
        .init_done(z_done)
    );

    // RAM macro: registered read with same-cycle write bypass
    always @(posedge clk) begin
        if (ram_re)
            ram_rd <= (ram_we && ram_waddr == ram_raddr) ? ram_wr : ram_mem[ram_raddr];
        if (ram_we)
            ram_mem[ram_waddr] <= ram_wr;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // reference model state
    bit          known = 0;
    bit          m_init = 0;
    int          m_cnt = 0;
    bit          m_r_a_next = 1, m_w_a_next = 1;
    bit          m_rva = 0, m_rvb = 0;
    logic [63:0] m_rdata = 0;
    logic [63:0] ref_mem [512];

    // compare process: one pass per cycle, away from the active edge
    always @(negedge clk) begin
        bit ga, gb, wa, wb;
        logic [8:0]  ra, wad;
        logic [63:0] wd;
        if (known) begin
            chk("a_rvalid", 64'(a_rvalid), 64'(m_rva));
            chk("b_rvalid", 64'(b_rvalid), 64'(m_rvb));
            chk("init_done", 64'(init_done), 64'(rst && !m_init));
            if (m_rva) chk("a_rdata", a_rdata, m_rdata);
            if (m_rvb) chk("b_rdata", b_rdata, m_rdata);
            chk("noinit_done", 64'(z_done), 64'(rst));
            chk("noinit_we", 64'(z_we), 64'd0);
        end
        if (!rst) begin
            chk("rst_gnt", 64'({a_rgnt, b_rgnt, a_wgnt, b_wgnt}), 64'd0);
            chk("rst_ram_en", 64'({ram_re, ram_we}), 64'd0);
            m_init = 1; m_cnt = 0;
            m_r_a_next = 1; m_w_a_next = 1;
            m_rva = 0; m_rvb = 0;
            known = 1;
        end else if (known && m_init) begin
            chk("init_gnt", 64'({a_rgnt, b_rgnt, a_wgnt, b_wgnt, ram_re}), 64'd0);
            chk("init_we", 64'(ram_we), 64'd1);
            chk("init_waddr", 64'(ram_waddr), 64'(m_cnt));
            chk("init_wr", ram_wr, IV);
            ref_mem[m_cnt] = IV;
            if (m_cnt == 511) m_init = 0;
            else m_cnt++;
            m_rva = 0; m_rvb = 0;
        end else if (known) begin
            ga = a_rreq && (!b_rreq || m_r_a_next);
            gb = b_rreq && !ga;
            wa = a_wreq && (!b_wreq || m_w_a_next);
            wb = b_wreq && !wa;
            if (ga) m_r_a_next = 0;
            if (gb) m_r_a_next = 1;
            if (wa) m_w_a_next = 0;
            if (wb) m_w_a_next = 1;
            chk("rgnt", 64'({a_rgnt, b_rgnt}), 64'({ga, gb}));
            chk("wgnt", 64'({a_wgnt, b_wgnt}), 64'({wa, wb}));
            chk("ram_re", 64'(ram_re), 64'(ga || gb));
            chk("ram_we", 64'(ram_we), 64'(wa || wb));
            ra  = ga ? a_raddr : b_raddr;
            wad = wa ? a_waddr : b_waddr;
            wd  = wa ? a_wdata : b_wdata;
            if (ga || gb) begin
                chk("ram_raddr", 64'(ram_raddr), 64'(ra));
                m_rdata = ((wa || wb) && wad == ra) ? wd : ref_mem[ra];
            end
            if (wa || wb) begin
                chk("ram_waddr", 64'(ram_waddr), 64'(wad));
                chk("ram_wr", ram_wr, wd);
                ref_mem[wad] = wd;
            end
            m_rva = ga; m_rvb = gb;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                            : 9'($urandom_range(0, 15));
    endfunction

    function automatic logic [63:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_n, done_cyc;
        int ca [4];
        int cb [4];
        bit ea [4];
        logic sa, sb, swa, swb;
        ca = '{1, 3, 3, 5};
        cb = '{2, 2, 4, 4};
        ea = '{1'b1, 1'b0, 1'b1, 1'b0};

        // reset, then interrupt the clear at clr_cnt=200
        rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (200) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midinit_done_low", 64'(init_done), 64'd0);
        step();
        rst = 1;

        // full clear sequence after the restart
        we_n = 0; done_cyc = 0;
        for (int c = 1; c <= 520; c++) begin
            @(negedge clk);
            if (c == 1) chk("restart_addr0", 64'(ram_waddr), 64'd0);
            if (c == 512) chk("last_clear_addr", 64'(ram_waddr), 64'd511);
            if (ram_we) we_n++;
            if (init_done && done_cyc == 0) done_cyc = c;
            step();
        end
        chk("init_we_cycles", 64'(we_n), 64'd512);
        chk("init_done_cycle", 64'(done_cyc), 64'd513);

        // read contention: strict alternation, A first
        a_rreq = 1; b_rreq = 1;
        for (int k = 0; k < 4; k++) begin
            a_raddr = 9'(ca[k]); b_raddr = 9'(cb[k]);
            @(negedge clk);
            chk("cont_a_rgnt", 64'(a_rgnt), 64'(ea[k]));
            chk("cont_b_rgnt", 64'(b_rgnt), 64'(!ea[k]));
            if (k > 0) begin
                chk("cont_a_rvalid", 64'(a_rvalid), 64'(ea[k-1]));
                chk("cont_rdata", a_rdata, IV);
            end
            step();
        end
        a_rreq = 0; b_rreq = 0;
        @(negedge clk);
        chk("cont_last_b_rvalid", 64'(b_rvalid), 64'd1);
        step();

        // single read of a cleared entry
        a_rreq = 1; a_raddr = 9'd300;
        @(negedge clk);
        chk("rd300_gnt", 64'(a_rgnt), 64'd1);
        step();
        a_rreq = 0;
        @(negedge clk);
        chk("rd300_valid", 64'(a_rvalid), 64'd1);
        chk("rd300_data", a_rdata, IV);
        step();

        // write then read back
        a_wreq = 1; a_waddr = 9'd5; a_wdata = 64'h1234;
        @(negedge clk);
        chk("wr5_gnt", 64'(a_wgnt), 64'd1);
        step();
        a_wreq = 0; a_rreq = 1; a_raddr = 9'd5;
        @(negedge clk);
        chk("rd5_gnt", 64'(a_rgnt), 64'd1);
        step();
        a_rreq = 0;
        @(negedge clk);
        chk("rd5_valid", 64'(a_rvalid), 64'd1);
        chk("rd5_data", a_rdata, 64'h1234);
        chk("rd5_b_quiet", 64'(b_rvalid), 64'd0);
        step();

        // same-cycle write by B and read by A of address 9
        b_wreq = 1; b_waddr = 9'd9; b_wdata = 64'hCAFE;
        a_rreq = 1; a_raddr = 9'd9;
        @(negedge clk);
        chk("byp_rgnt", 64'(a_rgnt), 64'd1);
        chk("byp_wgnt", 64'(b_wgnt), 64'd1);
        step();
        b_wreq = 0; a_rreq = 0;
        @(negedge clk);
        chk("byp_data", a_rdata, 64'hCAFE);
        step();

        // random traffic; each requester holds until granted
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            sa = a_rgnt; sb = b_rgnt; swa = a_wgnt; swb = b_wgnt;
            step();
            if (!a_rreq || sa) begin a_rreq = 1'($urandom_range(0, 1)); a_raddr = rnd_addr(); end
            if (!b_rreq || sb) begin b_rreq = 1'($urandom_range(0, 1)); b_raddr = rnd_addr(); end
            if (!a_wreq || swa) begin
                a_wreq = 1'($urandom_range(0, 1)); a_waddr = rnd_addr(); a_wdata = rnd_data();
            end
            if (!b_wreq || swb) begin
                b_wreq = 1'($urandom_range(0, 1)); b_waddr = rnd_addr(); b_wdata = rnd_data();
            end
        end
        a_rreq = 0; b_rreq = 0; a_wreq = 0; b_wreq = 0;
        step();
        step();

        // reset right after a read grant drops the response
        a_rreq = 1; a_raddr = 9'd7;
        @(negedge clk);
        chk("rst_rd_gnt", 64'(a_rgnt), 64'd1);
        step();
        a_rreq = 0; rst = 0;
        step();
        @(negedge clk);
        chk("rst_drop_rvalid", 64'(a_rvalid), 64'd0);
        step();
        rst = 1;
        repeat (520) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_512_64_ctrl.md
# ram_512_64_ctrl

Controller that sequences and shares one 512x64 1R1W RAM (1-cycle registered read, same-cycle same-address write bypass) between two requesters, A and B. After reset it clears every entry to a configurable value, then arbitrates the single read port and the single write port independently with round-robin fairness. Read responses are returned to the granted requester with a tagged valid. It sits directly in front of the 512x64 RAM macro and is the only block driving the RAM's ports.

## Interface
- INIT_EN, 1: 1 = run the clear sequence after reset; 0 = go straight to RUN.
- INIT_VALUE, 64'h0: data written to every entry during the clear sequence.

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low
- a_rreq / b_rreq  in  1  read request
- a_raddr / b_raddr  in  9  read address
- a_rgnt / b_rgnt  out  1  read accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid
- a_rdata / b_rdata  out  64  read data, meaningful only while the matching rvalid is 1
- a_wreq / b_wreq  in  1  write request
- a_waddr / b_waddr  in  9  write address
- a_wdata / b_wdata  in  64  write data
- a_wgnt / b_wgnt  out  1  write accepted this cycle (combinational)
- ram_re  out  1  RAM read enable
- ram_raddr  out  9  RAM read address
- ram_rd  in  64  RAM read data, 1 cycle after ram_re
- ram_we  out  1  RAM write enable
- ram_waddr  out  9  RAM write address
- ram_wr  out  64  RAM write data
- init_done  out  1  1 once in RUN

## Operation
- State machine:
  - States: INIT and RUN. When rst=0: state is INIT if INIT_EN=1, otherwise RUN. In both cases clr_cnt=0, rvalid regs=0, and both round-robin pointers are set to "A next".
  - INIT: ram_we=1, ram_waddr=clr_cnt, ram_wr=INIT_VALUE. clr_cnt increments each cycle. When clr_cnt==511 the write completes and the next state is RUN. clr_cnt saturates and never wraps.
  - INIT: all gnt=0 and ram_re=0. Requests are held off and are not dropped.
  - RUN: absorbing until reset. init_done=(state==RUN).
- Read arbitration (RUN only):
  - Only one requester asserts rreq: that requester is granted.
  - Both assert rreq: the requester named by rd_ptr is granted.
  - On any grant, rd_ptr flips to the other requester.
  - ram_re=a_rgnt|b_rgnt. ram_raddr=granted address (a_raddr when there is no grant).
- Read response:
  - Registers ra_q/rb_q capture a_rgnt/b_rgnt, so a_rvalid=ra_q and b_rvalid=rb_q.
  - a_rdata=b_rdata=ram_rd, passed through.
  - At most one rvalid is 1 per cycle.
- Write arbitration: same scheme with an independent wr_ptr. ram_we=a_wgnt|b_wgnt; address and data are muxed from the grantee.
- Read and write grants are independent, so one read and one write can issue in the same cycle.
- Same-cycle read and write to the same address: the RAM bypass returns the new data. The controller adds no hazard logic.
- While rst=0: every gnt, ram_re and ram_we is forced to 0.

## Timing
- Reset values: all gnt=0, rvalid=0, ram_re=0, ram_we=0, init_done=0. With INIT_EN=0, init_done is 1 in the first cycle after rst returns to 1.
- Clear sequence (INIT_EN=1):
  - 1st cycle with rst=1 writes address 0.
  - 512th cycle writes address 511.
  - 513th cycle: init_done=1 and grants may issue.
- Grant is combinational, in the same cycle as req. The requester must hold req, addr and data stable until its gnt is 1.
- Read latency: rvalid is exactly 1 cycle after rgnt. Back-to-back grants give back-to-back rvalids.
- rst=0 mid-INIT restarts the clear from address 0.
- rst=0 in RUN drops any in-flight response: rvalid is 0 in the next cycle.
- Continuous contention gives strict alternation: A, B, A, B..., with A first after reset.

## Test plan
- Reset with INIT_EN=1, INIT_VALUE=64'hDEAD_BEEF_0000_0001:
  - ram_we=1 for exactly 512 cycles with addresses 0..511 in order.
  - init_done rises on cycle 513.
  - A read of address 300 returns 64'hDEAD_BEEF_0000_0001.
- Single requester: A writes 0x1234 to address 5, then reads address 5 in the next cycle -> a_rgnt=1 in the request cycle, a_rvalid=1 one cycle later with a_rdata=0x1234, b_rvalid stays 0.
- Read contention: A and B both hold rreq for 4 cycles (A addresses 1..., B addresses 2...) -> grant order A, B, A, B; rvalid alternates a/b with the matching data, one cycle after each grant.
- Simultaneous access: in one cycle B writes 0xCAFE to address 9 and A reads address 9 -> both granted, and a_rdata=0xCAFE the next cycle.
- Reset mid-operation:
  - rst=0 in the cycle after an A read grant -> a_rvalid=0 next cycle.
  - rst=0 at clr_cnt=200 -> the clear restarts at address 0, and init_done stays 0 for the full 512 cycles.
- INIT_EN=0: after reset, ram_we stays 0 with no requests, and init_done=1 in the first cycle with rst=1.
